// File: rtl/inert_axis_seq.sv
// Inertial sensor SPI sequencer: powers up and configures the sensor, then on each
// data-ready interrupt reads NUM_AXES 16-bit axes and publishes them atomically.
module inert_axis_seq #(
  parameter int unsigned NUM_AXES  = 1,
  parameter logic [6:0]  BASE_ADDR = 7'h26,
  parameter int unsigned INIT_BITS = 16,
  parameter int unsigned TMO_CYC   = 1024,
  parameter logic [15:0] INIT0     = 16'h0D02,
  parameter logic [15:0] INIT1     = 16'h1160,
  parameter logic [15:0] INIT2     = 16'h1440
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    INT,
  input  logic                    done,
  input  logic [15:0]             resp,
  input  logic                    clr_ovr,
  output logic                    snd,
  output logic [15:0]             cmd,
  output logic [16*NUM_AXES-1:0]  rates,
  output logic                    vld,
  output logic                    init_done,
  output logic                    ovr,
  output logic                    err
);

  localparam int unsigned RW  = 16 * NUM_AXES;
  localparam int unsigned WDW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {PWR_WAIT, CFG, WAIT_INT, RD_H, RD_L} state_t;

  state_t                 state_q, state_d;
  logic [INIT_BITS-1:0]   wait_q, wait_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic [1:0]             cfg_q, cfg_d;
  logic [2:0]             ax_q, ax_d;
  logic [7:0]             hi_q, hi_d;
  logic [RW-1:0]          shadow_q, shadow_d;
  logic [RW-1:0]          rates_q, rates_d;
  logic [15:0]            cmd_q, cmd_d;
  logic                   snd_q, snd_d;
  logic                   vld_q, vld_d;
  logic                   init_done_q, init_done_d;
  logic                   ovr_q, ovr_d;
  logic                   err_q, err_d;
  logic                   int_s1_q, int_s2_q, int_s3_q;

  logic [6:0]             lo_addr_c;
  logic                   busy_c, done_v_c, tmo_c, rise_c;
  logic                   unused_c;

  assign unused_c = ^resp[15:8];

  // State and datapath registers; INT crosses through a 2-flop synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      wait_q      <= '0;
      wdog_q      <= '0;
      cfg_q       <= '0;
      ax_q        <= '0;
      hi_q        <= '0;
      shadow_q    <= '0;
      rates_q     <= '0;
      cmd_q       <= '0;
      snd_q       <= 1'b0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
      int_s1_q    <= 1'b0;
      int_s2_q    <= 1'b0;
      int_s3_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      wdog_q      <= wdog_d;
      cfg_q       <= cfg_d;
      ax_q        <= ax_d;
      hi_q        <= hi_d;
      shadow_q    <= shadow_d;
      rates_q     <= rates_d;
      cmd_q       <= cmd_d;
      snd_q       <= snd_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      int_s1_q    <= INT;
      int_s2_q    <= int_s1_q;
      int_s3_q    <= int_s2_q;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cfg_d       = cfg_q;
    ax_d        = ax_q;
    hi_d        = hi_q;
    shadow_d    = shadow_q;
    rates_d     = rates_q;
    cmd_d       = cmd_q;
    snd_d       = 1'b0;
    vld_d       = 1'b0;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    ovr_d       = ovr_q;

    lo_addr_c = BASE_ADDR + 7'({ax_q, 1'b0});
    busy_c    = (state_q == CFG) || (state_q == RD_H) || (state_q == RD_L);
    // A completion in the start cycle is not accepted, so snd can never repeat back-to-back.
    done_v_c  = done & ~snd_q;
    tmo_c     = busy_c & ~done_v_c & (wdog_q == WDW'(TMO_CYC - 1));
    rise_c    = int_s2_q & ~int_s3_q;

    case (state_q)
      PWR_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (&wait_q) begin
          snd_d   = 1'b1;
          cmd_d   = INIT0;
          cfg_d   = 2'd0;
          state_d = CFG;
        end
      end
      CFG: begin
        if (done_v_c) begin
          if (cfg_q == 2'd0) begin
            snd_d = 1'b1;
            cmd_d = INIT1;
            cfg_d = 2'd1;
          end else if (cfg_q == 2'd1) begin
            snd_d = 1'b1;
            cmd_d = INIT2;
            cfg_d = 2'd2;
          end else begin
            init_done_d = 1'b1;
            state_d     = WAIT_INT;
          end
        end else if (tmo_c) begin
          err_d   = 1'b1;
          wait_d  = '0;
          cfg_d   = 2'd0;
          state_d = PWR_WAIT;
        end
      end
      WAIT_INT: begin
        if (int_s2_q) begin
          ax_d    = 3'd0;
          snd_d   = 1'b1;
          cmd_d   = {1'b1, BASE_ADDR + 7'd1, 8'h00};
          state_d = RD_H;
        end
      end
      RD_H: begin
        if (done_v_c) begin
          hi_d    = resp[7:0];
          snd_d   = 1'b1;
          cmd_d   = {1'b1, lo_addr_c, 8'h00};
          state_d = RD_L;
        end else if (tmo_c) begin
          err_d    = 1'b1;
          shadow_d = '0;
          ax_d     = 3'd0;
          state_d  = WAIT_INT;
        end
      end
      RD_L: begin
        if (done_v_c) begin
          for (int k = 0; k < NUM_AXES; k++) begin
            if (ax_q == 3'(k)) shadow_d[16*k +: 16] = {hi_q, resp[7:0]};
          end
          if (ax_q != 3'(NUM_AXES - 1)) begin
            ax_d    = ax_q + 3'd1;
            snd_d   = 1'b1;
            cmd_d   = {1'b1, lo_addr_c + 7'd3, 8'h00};
            state_d = RD_H;
          end else begin
            rates_d = shadow_d;
            vld_d   = 1'b1;
            state_d = WAIT_INT;
          end
        end else if (tmo_c) begin
          err_d    = 1'b1;
          shadow_d = '0;
          ax_d     = 3'd0;
          state_d  = WAIT_INT;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    if (rise_c && ((state_q == RD_H) || (state_q == RD_L))) ovr_d = 1'b1;
    else if (clr_ovr)                                        ovr_d = 1'b0;

    wdog_d = (snd_d || !busy_c) ? '0 : wdog_q + 1'b1;
  end

  assign snd       = snd_q;
  assign cmd       = cmd_q;
  assign rates     = rates_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign ovr       = ovr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inert_axis_seq.sv
// Bench for inert_axis_seq: a behavioural sensor (register array + SPI responder)
// drives the sequencer; expected rates come from the sensor register contents.
module tb_inert_axis_seq;
  localparam int NA   = 3;
  localparam int IB   = 4;
  localparam int TMO  = 64;
  localparam int BASE = 'h26;

  logic clk = 1'b0;
  logic rst = 1'b1, sens_int = 1'b0, clr_ovr = 1'b0;
  logic done, snd, vld, init_done, ovr, err;
  logic [15:0] resp, cmd;
  logic [16*NA-1:0] rates;

  always #5 clk = ~clk;

  inert_axis_seq #(.NUM_AXES(NA), .BASE_ADDR(7'h26), .INIT_BITS(IB), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .INT(sens_int), .done(done), .resp(resp), .clr_ovr(clr_ovr),
    .snd(snd), .cmd(cmd), .rates(rates), .vld(vld), .init_done(init_done), .ovr(ovr), .err(err));

  // Sensor model state
  logic [7:0]  mem [0:127];
  logic [15:0] cmd_log [$];
  int drop_at = -1, lat_max = 3, spur_req = 0, spur_ack = 0, wait_cnt = 0;
  bit hold = 1'b0;
  logic [15:0] pend_resp;

  int n_chk = 0, n_fail = 0;
  int vld_cnt = 0, err_cnt = 0, snd_dbl = 0, rates_bad = 0;
  logic snd_prev = 1'b0;
  logic [16*NA-1:0] rates_prev = '0;

  // SPI responder: logs every command and answers reads from mem after a random latency.
  initial begin
    done = 1'b0;
    resp = 16'h0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (wait_cnt > 0) begin
        if (!hold) wait_cnt--;
        if (wait_cnt == 0) begin done = 1'b1; resp = pend_resp; end
      end else if (spur_req != spur_ack) begin
        spur_ack++;
        done = 1'b1;
        resp = 16'hFFFF;
      end else if (snd === 1'b1) begin
        cmd_log.push_back(cmd);
        if (cmd_log.size() - 1 != drop_at) begin
          wait_cnt  = $urandom_range(lat_max, 1);
          pend_resp = cmd[15] ? {8'($urandom), mem[cmd[14:8]]} : 16'($urandom);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vld === 1'b1) vld_cnt <= vld_cnt + 1;
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (snd === 1'b1 && snd_prev === 1'b1) snd_dbl <= snd_dbl + 1;
    if (rates !== rates_prev && vld !== 1'b1 && rst !== 1'b1) rates_bad <= rates_bad + 1;
    snd_prev   <= snd;
    rates_prev <= rates;
  end

  function automatic logic [16*NA-1:0] exp_rates();
    logic [16*NA-1:0] r;
    for (int k = 0; k < NA; k++) r[16*k +: 16] = {mem[BASE + 2*k + 1], mem[BASE + 2*k]};
    return r;
  endfunction

  function automatic logic [15:0] exp_rd_cmd(input int i);
    int a;
    a = BASE + 2 * (i / 2) + ((i % 2 == 0) ? 1 : 0);
    return 16'h8000 | 16'(a << 8);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
  endtask

  // Raise INT until the burst starts, then wait for vld.
  task automatic run_burst(output int nsnd, output bit got);
    nsnd = 0;
    got  = 1'b0;
    sens_int = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (snd === 1'b1) begin nsnd++; sens_int = 1'b0; end
      if (vld === 1'b1) got = 1'b1;
    end
    sens_int = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_chk++;
    if ({snd, cmd, vld, init_done, ovr, err} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_ctl: snd=%b cmd=%h vld=%b init_done=%b ovr=%b err=%b, want all 0",
               snd, cmd, vld, init_done, ovr, err);
    end
    n_chk++;
    if (rates !== '0) begin n_fail++; $display("FAIL reset_rates: got %h want 0", rates); end
  endtask

  task automatic test_init();
    int n = 0, b;
    b = cmd_log.size();
    rst = 1'b0;
    while (snd !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_chk++;
    if (n != (1 << IB)) begin n_fail++; $display("FAIL init_wait: first snd after %0d cycles, want %0d", n, 1 << IB); end
    n_chk++;
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_early: init_done=%b want 0", init_done); end
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    n_chk++;
    if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", init_done); end
    step(4);
    n_chk++;
    if (cmd_log.size() - b != 3) begin n_fail++; $display("FAIL init_count: %0d cmds want 3", cmd_log.size() - b); end
    else begin
      n_chk++;
      if ({cmd_log[b], cmd_log[b+1], cmd_log[b+2]} !== {16'h0D02, 16'h1160, 16'h1440}) begin
        n_fail++;
        $display("FAIL init_cmds: got %h %h %h want 0d02 1160 1440", cmd_log[b], cmd_log[b+1], cmd_log[b+2]);
      end
    end
  endtask

  task automatic check_burst(input string nm, input int b, input int nsnd, input bit got);
    n_chk++;
    if (!got || nsnd != 2 * NA) begin
      n_fail++;
      $display("FAIL %s_done: vld=%0b snds=%0d want vld=1 snds=%0d", nm, got, nsnd, 2 * NA);
    end
    n_chk++;
    if (rates !== exp_rates()) begin n_fail++; $display("FAIL %s_rates: got %h want %h", nm, rates, exp_rates()); end
    for (int i = 0; i < 2 * NA && b + i < cmd_log.size(); i++) begin
      n_chk++;
      if (cmd_log[b+i] !== exp_rd_cmd(i)) begin
        n_fail++;
        $display("FAIL %s_cmd%0d: got %h want %h", nm, i, cmd_log[b+i], exp_rd_cmd(i));
      end
    end
  endtask

  task automatic test_burst();
    int b, nsnd, v0;
    bit got;
    randomize_mem();
    mem['h27] = 8'h34; mem['h26] = 8'h12;
    mem['h29] = 8'h78; mem['h28] = 8'h56;
    mem['h2B] = 8'hBC; mem['h2A] = 8'h9A;
    b = cmd_log.size();
    v0 = vld_cnt;
    run_burst(nsnd, got);
    check_burst("burst", b, nsnd, got);
    n_chk++;
    if (rates !== 48'hBC9A_7856_3412) begin n_fail++; $display("FAIL burst_fixed: got %h want bc9a78563412", rates); end
    step(3);
    n_chk++;
    if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL burst_vld_pulse: %0d vld cycles want 1", vld_cnt - v0); end
    n_chk++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL burst_ovr: got %b want 0", ovr); end
  endtask

  task automatic test_random();
    int b, nsnd, s0;
    bit got;
    for (int it = 0; it < 4; it++) begin
      randomize_mem();
      lat_max = $urandom_range(4, 1);
      b = cmd_log.size();
      run_burst(nsnd, got);
      check_burst("random", b, nsnd, got);
      step($urandom_range(5, 2));
    end
    lat_max = 3;
    s0 = cmd_log.size();
    spur_req++;
    step(8);
    n_chk++;
    if (cmd_log.size() != s0) begin n_fail++; $display("FAIL spurious_done: %0d snds want 0", cmd_log.size() - s0); end
  endtask

  task automatic test_timeout();
    int b, nsnd = 0, t0 = -1, terr = -1, v0, e0;
    logic [16*NA-1:0] r0;
    bit got;
    r0 = rates;
    v0 = vld_cnt;
    e0 = err_cnt;
    b = cmd_log.size();
    drop_at = b + 3;
    sens_int = 1'b1;
    for (int i = 0; i < 600 && terr < 0; i++) begin
      @(negedge clk);
      if (snd === 1'b1) begin nsnd++; sens_int = 1'b0; if (nsnd == 4) t0 = i; end
      if (err === 1'b1) terr = i;
    end
    sens_int = 1'b0;
    step(3);
    drop_at = -1;
    n_chk++;
    if (terr < 0 || t0 < 0 || terr - t0 != TMO) begin
      n_fail++;
      $display("FAIL tmo_delay: err %0d cycles after snd want %0d", terr - t0, TMO);
    end
    n_chk++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL tmo_err_pulse: %0d err cycles want 1", err_cnt - e0); end
    n_chk++;
    if (vld_cnt != v0 || rates !== r0) begin
      n_fail++;
      $display("FAIL tmo_rates: vld=%0d rates=%h want vld=0 rates=%h", vld_cnt - v0, rates, r0);
    end
    randomize_mem();
    b = cmd_log.size();
    run_burst(nsnd, got);
    check_burst("post_tmo", b, nsnd, got);
  endtask

  task automatic test_ovr();
    int n = 0;
    bit got = 1'b0;
    hold = 1'b1;
    sens_int = 1'b1;
    while (snd !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    step(1);
    sens_int = 1'b0;
    step(4);
    sens_int = 1'b1;
    step(2);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    n_chk++;
    if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ovr); end
    step(3);
    n_chk++;
    if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", ovr); end
    sens_int = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin @(negedge clk); if (vld === 1'b1) got = 1'b1; end
    n_chk++;
    if (!got || ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_after_burst: vld=%b ovr=%b want 1 1", got, ovr); end
    step(2);
    clr_ovr = 1'b1;
    step(1);
    clr_ovr = 1'b0;
    n_chk++;
    if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ovr); end
  endtask

  task automatic test_reset_mid();
    int b, nsnd = 0, v0, e0, n = 0;
    randomize_mem();
    b = cmd_log.size();
    drop_at = b + 5;
    sens_int = 1'b1;
    for (int i = 0; i < 300 && nsnd < 6; i++) begin
      @(negedge clk);
      if (snd === 1'b1) begin nsnd++; sens_int = 1'b0; end
    end
    sens_int = 1'b0;
    step(2);
    v0 = vld_cnt;
    e0 = err_cnt;
    rst = 1'b1;
    step(1);
    n_chk++;
    if ({snd, cmd, vld, init_done, ovr, err} !== 20'h0 || rates !== '0) begin
      n_fail++;
      $display("FAIL midrst_zero: snd=%b cmd=%h rates=%h vld=%b init_done=%b ovr=%b err=%b, want all 0",
               snd, cmd, rates, vld, init_done, ovr, err);
    end
    step(1);
    rst = 1'b0;
    drop_at = -1;
    b = cmd_log.size();
    while (init_done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    step(2);
    n_chk++;
    if (init_done !== 1'b1 || cmd_log.size() - b != 3) begin
      n_fail++;
      $display("FAIL midrst_cfg: init_done=%b cmds=%0d want 1 3", init_done, cmd_log.size() - b);
    end else begin
      n_chk++;
      if ({cmd_log[b], cmd_log[b+1], cmd_log[b+2]} !== {16'h0D02, 16'h1160, 16'h1440}) begin
        n_fail++;
        $display("FAIL midrst_cmds: got %h %h %h want 0d02 1160 1440", cmd_log[b], cmd_log[b+1], cmd_log[b+2]);
      end
    end
    n_chk++;
    if (vld_cnt != v0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL midrst_pulses: vld=%0d err=%0d want 0 0", vld_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_invariants();
    n_chk++;
    if (snd_dbl != 0) begin n_fail++; $display("FAIL snd_back_to_back: %0d occurrences want 0", snd_dbl); end
    n_chk++;
    if (rates_bad != 0) begin n_fail++; $display("FAIL rates_without_vld: %0d changes want 0", rates_bad); end
  endtask

  initial begin
    randomize_mem();
    test_reset();
    test_init();
    test_burst();
    test_random();
    test_timeout();
    test_ovr();
    test_reset_mid();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
